// File: rtl/hdc_pkg.sv
// hdc_pkg: shared types, defaults and index widths for the sparse HDC datapath
package hdc_pkg;
    typedef logic [3:0] level_t;
    typedef enum logic {IDLE, EMIT} enc_state_t;
    localparam int N_LEVELS   = 10;
    localparam int N_FEATURES = 3;
    localparam int N_SEG      = 4;
    localparam int SEG_LEN    = 64;
    localparam int SEG_STRIDE = 5;
    localparam int LEVEL_STEP = 6;
    localparam int FEAT_STEP  = 17;
    localparam int IDX_W      = $clog2(SEG_LEN);
    localparam int SEG_W      = $clog2(N_SEG);
    localparam int FEAT_W     = $clog2(N_FEATURES);
endpackage

// File: rtl/sparse_idx_calc.sv
// sparse_idx_calc: combinational active index (seg*stride + lvl*lstep + feat*fstep) mod seg_len; in seg/lvl/feat, out idx
module sparse_idx_calc
    import hdc_pkg::*;
#(
    parameter int SEG_LEN    = hdc_pkg::SEG_LEN,
    parameter int SEG_STRIDE = hdc_pkg::SEG_STRIDE,
    parameter int LEVEL_STEP = hdc_pkg::LEVEL_STEP,
    parameter int FEAT_STEP  = hdc_pkg::FEAT_STEP,
    parameter int SEG_W      = hdc_pkg::SEG_W,
    parameter int FEAT_W     = hdc_pkg::FEAT_W,
    parameter int IDX_W      = $clog2(SEG_LEN)
) (
    input  logic [SEG_W-1:0]  seg,
    input  level_t            lvl,
    input  logic [FEAT_W-1:0] feat,
    output logic [IDX_W-1:0]  idx
);
    logic [31:0] sum;
    always_comb begin
        sum = 32'(seg) * 32'(SEG_STRIDE) + 32'(lvl) * 32'(LEVEL_STEP) + 32'(feat) * 32'(FEAT_STEP);
        idx = IDX_W'(sum % 32'(SEG_LEN));
    end
endmodule

// File: rtl/sparse_level_encoder.sv
// sparse_level_encoder: binds a quantized level with its feature slot and streams one active index per segment; level in (valid/ready), index beats out (valid/ready), sticky lvl_err
module sparse_level_encoder
    import hdc_pkg::*;
#(
    parameter int N_LEVELS   = hdc_pkg::N_LEVELS,
    parameter int N_FEATURES = hdc_pkg::N_FEATURES,
    parameter int N_SEG      = hdc_pkg::N_SEG,
    parameter int SEG_LEN    = hdc_pkg::SEG_LEN,
    parameter int SEG_STRIDE = hdc_pkg::SEG_STRIDE,
    parameter int LEVEL_STEP = hdc_pkg::LEVEL_STEP,
    parameter int FEAT_STEP  = hdc_pkg::FEAT_STEP,
    localparam int IW = $clog2(SEG_LEN),
    localparam int SW = $clog2(N_SEG),
    localparam int FW = $clog2(N_FEATURES)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          en,
    input  logic          in_valid,
    output logic          in_ready,
    input  level_t        in_level,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output logic [SW-1:0] out_seg,
    output logic [FW-1:0] out_feat,
    output logic          out_last_seg,
    output logic          out_last_feat,
    output logic          lvl_err
);
    enc_state_t state, next_state;
    logic [SW-1:0] seg_cnt;
    logic [FW-1:0] feat_cnt;
    level_t lvl;
    logic last_seg, last_feat, in_fire, out_fire, oor;
    assign last_seg  = seg_cnt == SW'(N_SEG - 1);
    assign last_feat = feat_cnt == FW'(N_FEATURES - 1);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign oor       = int'(in_level) >= N_LEVELS;
    always_ff @(posedge clk)
        state <= nrst ? IDLE : next_state;
    always_comb
        next_state = (state == IDLE || (out_fire && last_seg)) ? (in_fire ? EMIT : IDLE) : EMIT;
    // in_ready reopens during EMIT only on the final-segment handshake, giving back-to-back HVs
    always_comb begin
        out_valid = !nrst && en && state == EMIT;
        in_ready  = !nrst && en && (state == IDLE || (out_valid && out_ready && last_seg));
    end
    always_ff @(posedge clk) begin
        if (nrst) begin
            seg_cnt  <= '0;
            feat_cnt <= '0;
            lvl      <= '0;
            lvl_err  <= 1'b0;
        end else begin
            if (in_fire) begin
                lvl     <= oor ? level_t'(N_LEVELS - 1) : in_level;
                lvl_err <= lvl_err | oor;
            end
            if (in_fire)
                seg_cnt <= '0;
            else if (out_fire)
                seg_cnt <= seg_cnt + 1'b1;
            if (out_fire && last_seg)
                feat_cnt <= last_feat ? '0 : feat_cnt + 1'b1;
        end
    end
    sparse_idx_calc #(
        .SEG_LEN(SEG_LEN), .SEG_STRIDE(SEG_STRIDE), .LEVEL_STEP(LEVEL_STEP),
        .FEAT_STEP(FEAT_STEP), .SEG_W(SW), .FEAT_W(FW), .IDX_W(IW)
    ) u_idx (
        .seg(seg_cnt), .lvl(lvl), .feat(feat_cnt), .idx(out_idx)
    );
    assign out_seg       = seg_cnt;
    assign out_feat      = feat_cnt;
    assign out_last_seg  = last_seg;
    assign out_last_feat = last_feat;
endmodule

// File: tb/tb_sparse_level_encoder.sv
// tb_sparse_level_encoder: scoreboard bench for sparse_level_encoder
module tb_sparse_level_encoder;
    logic clk = 0, nrst = 1, en = 1, in_valid = 0, in_ready, out_valid, out_ready = 1;
    logic [3:0] in_level = 0;
    logic [5:0] out_idx;
    logic [1:0] out_seg, out_feat;
    logic out_last_seg, out_last_feat, lvl_err;
    int checks = 0, errors = 0, mfeat = 0;
    typedef struct {int idx; int seg; int feat; int ls; int lf;} beat_t;
    beat_t q[$];

    sparse_level_encoder dut (
        .clk(clk), .nrst(nrst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .in_level(in_level), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_seg(out_seg), .out_feat(out_feat),
        .out_last_seg(out_last_seg), .out_last_feat(out_last_feat), .lvl_err(lvl_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_hv(input int lvl);
        int l = lvl >= 10 ? 9 : lvl;
        for (int s = 0; s < 4; s++)
            q.push_back('{(s * 5 + l * 6 + mfeat * 17) % 64, s, mfeat, int'(s == 3), int'(mfeat == 2)});
        mfeat = (mfeat + 1) % 3;
    endtask

    // accept one level, then check the first beat shows up the very next cycle
    task automatic send(input int lvl);
        int n = 0;
        bit ok = 0;
        in_valid = 1;
        in_level = 4'(lvl);
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            n++;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        else push_hv(lvl);
        @(posedge clk) #1;
        in_valid = 0;
        in_level = 4'hF;
        @(negedge clk);
        if (ok) chk("latency", int'(out_valid), 1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        @(posedge clk) #1;
    endtask

    task automatic cycle();
        @(posedge clk) #1;
    endtask

    always @(negedge clk) begin
        if (!nrst && out_valid) begin
            if (q.size() == 0) chk("spurious_beat", 1, 0);
            else begin
                chk("idx", int'(out_idx), q[0].idx);
                chk("seg", int'(out_seg), q[0].seg);
                chk("feat", int'(out_feat), q[0].feat);
                chk("last_seg", int'(out_last_seg), q[0].ls);
                chk("last_feat", int'(out_last_feat), q[0].lf);
                chk("in_ready_emit", int'(in_ready), int'(q[0].seg == 3 && out_ready));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        cycle();
        cycle();
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        @(posedge clk) #1;
        nrst = 0;
        @(negedge clk);
        chk("idle_out_valid", int'(out_valid), 0);
        chk("idle_in_ready", int'(in_ready), 1);
        chk("idle_lvl_err", int'(lvl_err), 0);
        chk("idle_idx", int'(out_idx), 0);
        chk("idle_feat", int'(out_feat), 0);
        cycle();
        send(0);
        drain();
        send(9);
        send(3);
        drain();
        chk("no_err_yet", int'(lvl_err), 0);
        send(12);
        drain();
        chk("lvl_err_set", int'(lvl_err), 1);
        out_ready = 0;
        send(5);
        out_ready = 1;
        cycle();
        out_ready = 0;
        repeat (3) cycle();
        en = 0;
        @(negedge clk);
        chk("en0_out_valid", int'(out_valid), 0);
        chk("en0_in_ready", int'(in_ready), 0);
        cycle();
        @(negedge clk);
        chk("en0_out_valid2", int'(out_valid), 0);
        cycle();
        en = 1;
        out_ready = 1;
        drain();
        chk("lvl_err_sticky", int'(lvl_err), 1);
        send(7);
        begin
            int n = 0;
            while (!(out_valid && out_seg == 2) && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("reach_seg2", int'(out_seg), 2);
        end
        @(posedge clk) #1;
        nrst = 1;
        q.delete();
        mfeat = 0;
        @(posedge clk) #1;
        nrst = 0;
        @(negedge clk);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_feat", int'(out_feat), 0);
        chk("mid_rst_seg", int'(out_seg), 0);
        chk("mid_rst_lvl_err", int'(lvl_err), 0);
        cycle();
        send(2);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sparse_level_encoder.md
Name: sparse_level_encoder

Overview:
- Sits directly downstream of the Quantizer in the sparse HDC datapath.
- Takes one 4-bit quantized level per feature and binds it with a feature position.
- Emits the resulting segmented sparse hypervector: one active index per segment, serialised one segment per output beat over a valid/ready stream.
- The downstream bundler consumes the index stream and uses the frame-boundary flags.

Parameters:
- N_LEVELS, 10, number of quantizer levels; legal in_level is 0..N_LEVELS-1
- N_FEATURES, 3, features per frame; feature counter wraps after N_FEATURES-1
- N_SEG, 4, segments per hypervector (power of 2)
- SEG_LEN, 64, bits per segment (power of 2); D = N_SEG*SEG_LEN
- SEG_STRIDE, 5, per-segment base offset
- LEVEL_STEP, 6, index offset per level step (gives level locality)
- FEAT_STEP, 17, index offset per feature (binding by rotation)

Ports:
- clk  in  1  clock; all logic rising-edge
- nrst  in  1  reset; synchronous, active-high (1 = reset)
- en  in  1  global enable, same meaning as Quantizer en
- in_valid  in  1  level valid
- in_ready  out  1  encoder can accept a level
- in_level  in  4  quantized level from Quantizer
- out_valid  out  1  index beat valid
- out_ready  in  1  downstream accepts beat
- out_idx  out  $clog2(SEG_LEN)  active bit index within segment
- out_seg  out  $clog2(N_SEG)  segment number
- out_feat  out  $clog2(N_FEATURES)  feature number of this HV
- out_last_seg  out  1  beat is segment N_SEG-1
- out_last_feat  out  1  HV belongs to feature N_FEATURES-1 (frame end when combined with out_last_seg)
- lvl_err  out  1  sticky: an out-of-range level was received

Behaviour:
- Reset (nrst=1 at edge): FSM=IDLE, seg_cnt=0, feat_cnt=0, held level=0, lvl_err=0. Outputs in reset: out_valid=0, in_ready=0, others 0. Reset mid-HV discards the partial HV and restarts at feature 0.
- FSM states: IDLE, EMIT.
- IDLE:
  - in_ready=en.
  - On in_valid&&in_ready: latch level, seg_cnt=0, go to EMIT.
- EMIT:
  - out_valid=en; outputs are registered-state driven.
  - out_idx = (seg_cnt*SEG_STRIDE + lvl*LEVEL_STEP + feat_cnt*FEAT_STEP) mod SEG_LEN.
  - Compute at full width, then truncate to $clog2(SEG_LEN) bits; no saturation.
  - Handshake on out_valid&&out_ready: seg_cnt++.
- Last segment: on the handshake of seg_cnt==N_SEG-1:
  - feat_cnt increments, wrapping N_FEATURES-1 -> 0.
  - If in_valid is also high that same cycle, the new level is accepted: in_ready=en is asserted combinationally in this case only. FSM stays in EMIT with seg_cnt=0. This gives back-to-back throughput of N_SEG cycles per feature.
  - Otherwise the FSM returns to IDLE.
- Latency: level accepted at edge N -> first beat valid in the cycle after edge N.
- Stall: out_valid=1 with out_ready=0 holds all out_* stable until accepted.
- en=0:
  - in_ready=0 and out_valid=0; all registers hold.
  - When en returns to 1, the same pending beat is re-presented.
  - Reset has priority over en.
- Out-of-range level (in_level>=N_LEVELS) on acceptance: clamp to N_LEVELS-1 and set lvl_err. lvl_err is cleared only by reset.
- in_level is sampled only on handshake; changes at other times are ignored.

Decomposition:
- Package hdc_pkg holds:
  - level_t (4-bit logic) and the N_LEVELS default, shared with Quantizer
  - enc_state_t enum {IDLE, EMIT}
  - index-width localparams derived via $clog2
- Sub-module sparse_idx_calc: combinational index arithmetic and mod truncation, reused by the later item-memory stage.
- The FSM and counters stay in the top module.

Test Plan:
- Feature 0, level 0, out_ready=1 -> beats idx 0,5,10,15 on seg 0..3, first beat one cycle after accept, in_ready low during beats 0..2.
- Feature 1, level 9, with in_valid held high across the last beat -> idx 7,12,17,22. The next level is accepted on the seg-3 handshake, with no idle cycle between HVs.
- Feature 2, level 3 -> idx 52,57,62,3 (wrap). out_last_feat=1 and out_last_seg=1 on the final beat; the next HV reports out_feat=0.
- out_ready low 3 cycles on seg 1, then en=0 for 2 cycles:
  - out_* stable through the out_ready stall;
  - out_valid=0 while en=0;
  - the same beat resumes afterwards with nothing lost or duplicated.
- in_level=12 -> treated as level 9 (feature 0 idx 54,59,0,5), and lvl_err=1 persists until nrst pulse.
- nrst=1 for one cycle mid-HV (after seg 1) -> out_valid=0 and feat_cnt=0 next cycle; a new level restarts at feature 0 and seg 0.
